dac_sample_tx: RTL
==================

// Module: dac_sample_tx
// PURPOSE
//  Transmit side of the analogue front end. Takes unsigned 8-bit samples from the processing chain
//  and buffers them in a small FIFO. Paces them out at a programmable rate and drives a parallel
//  8-bit DAC (data bus plus sample clock).
//  Signed output mode subtracts 127, exactly inverting the ADC capture path's +127 offset, so a
//  capture->transmit loopback is identity.
// PARAMETERS
//  DATA_W     8    sample width
//  FIFO_DEPTH 16   sample buffer depth, power of 2, >=4
//  DIV_W      16   width of rate divider
//  TWOS_COMP  0    0: dac_data = unsigned sample; 1: dac_data = (sample - 8'd127) mod 256
//  IDLE_CODE  127  unsigned code driven when idle, before format conversion
// PORTS
//  clk            in   1       system clock; also source of dac_clk
//  rst            in   1       synchronous, active-high reset
//  enable         in   1       1 = stream samples; 0 = stop, flush, drive idle code
//  rate_div       in   DIV_W   output one sample every rate_div+1 clk cycles; sampled at tick boundaries
//  s_data         in   DATA_W  unsigned input sample
//  s_valid        in   1       s_data valid
//  s_ready        out  1       FIFO can accept; transfer when s_valid & s_ready on posedge clk
//  dac_clk        out  1       ~clk; DAC latches on its rising edge, mid-cycle of clk
//  dac_data       out  DATA_W  registered DAC code
//  dac_strobe     out  1       1-cycle pulse when dac_data took a new FIFO sample
//  underflow      out  1       1-cycle pulse: tick in RUN with FIFO empty
//  underflow_cnt  out  16      saturating underflow count; cleared by rst or enable rising edge
//  fifo_level     out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
// BEHAVIOUR
//  Reset values: dac_data = conv(IDLE_CODE), s_ready = 0, dac_strobe = 0, underflow = 0,
//  underflow_cnt = 0, fifo_level = 0, state = IDLE, divider = 0.
//  Divider:
//   - counter 0..rate_div; tick when count == rate_div, then count <= 0.
//   - rate_div = 0 gives a tick every cycle.
//   - A new rate_div value takes effect after the next tick.
//  FSM:
//   IDLE : enable = 0. FIFO held flushed, s_ready = 0, dac_data = conv(IDLE_CODE), divider held at 0.
//          enable = 1 -> PRIME.
//   PRIME: s_ready = !full; no pops. When fifo_level >= FIFO_DEPTH/2 -> RUN, divider starts from 0.
//   RUN  : s_ready = !full. On each tick:
//          - FIFO non-empty: pop; dac_data <= conv(head) on the same posedge; dac_strobe = 1.
//          - FIFO empty: dac_data holds its last value; underflow = 1; underflow_cnt += 1
//            (saturates at 16'hFFFF). Stay in RUN.
//   Any state with enable = 0 -> IDLE on the next posedge: FIFO flushed, idle code driven the same
//   cycle IDLE is entered.
//  Latency: tick with non-empty FIFO -> dac_data updated at that posedge -> DAC latches half a clk later.
//  FIFO:
//   - No write-through bypass: a sample pushed in the same cycle a tick finds the FIFO empty is NOT
//     output; that tick is an underflow.
//   - Push and pop in the same cycle (not full, not empty) -> level unchanged.
//   - s_ready is derived from the registered full flag, so a push is never dropped.
//   - Pointers wrap modulo FIFO_DEPTH.
//  conv(x): TWOS_COMP = 0 -> x; TWOS_COMP = 1 -> x - 8'd127 (mod 256). Purely combinational ahead of
//  the dac_data register.
//  rst asserted mid-stream: all state returns to reset values at that posedge; in-flight samples are lost.
// STRUCTURE
//  Shared header dac_defs.vh: IDLE_CODE default, ADC_OFFSET = 8'd127 (shared with the capture block),
//  FSM state encodings IDLE = 2'd0, PRIME = 2'd1, RUN = 2'd2.
//  One sub-module: sync_fifo (DATA_W, FIFO_DEPTH; push/pop/flush, full/empty/level).
//  Divider, FSM and output register live in the top.
// TESTING
//  1 Reset/idle: rst = 1 for 2 cycles, enable = 0 -> dac_data = 127 (TWOS_COMP = 0), s_ready = 0,
//    underflow_cnt = 0.
//  2 Streaming: enable = 1, rate_div = 3, push 0,1,..,15 -> RUN after 8 samples; dac_data steps
//    0,1,2.. every 4 cycles; dac_strobe pulses 4 cycles apart; no underflow.
//  3 Underflow: rate_div = 0, push 8 samples then stop -> 8 strobes, then an underflow pulse every
//    cycle, dac_data holds 7, underflow_cnt increments by 1 per cycle.
//  4 Full/backpressure: rate_div = 100, hold s_valid = 1 -> s_ready drops once fifo_level = 16; no
//    sample lost or duplicated.
//  5 Signed mode: TWOS_COMP = 1, push 127, 255, 0 -> dac_data = 0x00, 0x80, 0x81; idle code -> 0x00.
//  6 Abort: drop enable mid-RUN with level = 5 -> next cycle IDLE, fifo_level = 0, dac_data = idle code.
//    Assert rst mid-RUN -> same result, and underflow_cnt = 0.

Source files
------------

// File: rtl/dac_sample_tx_pkg.sv
// dac_sample_tx_pkg: shared constants and FSM encoding for the DAC transmit path
package dac_sample_tx_pkg;
    localparam logic [7:0] ADC_OFFSET        = 8'd127;
    localparam logic [7:0] IDLE_CODE_DEFAULT = 8'd127;
    typedef enum logic [1:0] {IDLE = 2'd0, PRIME = 2'd1, RUN = 2'd2} state_t;
endpackage

// File: rtl/dac_sample_tx_fifo.sv
// dac_sample_tx_fifo: synchronous sample FIFO with flush and registered occupancy
module dac_sample_tx_fifo #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  logic                          pop,
    input  logic                          flush,
    input  logic [DATA_W-1:0]             data,
    output logic [DATA_W-1:0]             head,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   level
);
    localparam int AW = $clog2(FIFO_DEPTH);
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr, rd;
    logic wr_en, rd_en;
    assign full  = level[AW];
    assign empty = level == '0;
    assign head  = mem[rd];
    assign wr_en = push && !full;
    assign rd_en = pop && !empty;
    // pointers and occupancy; flush drops everything in flight
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr    <= '0;
            rd    <= '0;
            level <= '0;
        end else begin
            if (wr_en) wr <= wr + 1'b1;
            if (rd_en) rd <= rd + 1'b1;
            level <= level + (AW+1)'(wr_en) - (AW+1)'(rd_en);
        end
    end
    // sample storage
    always_ff @(posedge clk) begin
        if (wr_en && !flush) mem[wr] <= data;
    end
endmodule

// File: rtl/dac_sample_tx.sv
// dac_sample_tx: buffers samples and paces them out to a parallel DAC at a programmable rate
module dac_sample_tx
    import dac_sample_tx_pkg::*;
#(
    parameter int                DATA_W     = 8,
    parameter int                FIFO_DEPTH = 16,
    parameter int                DIV_W      = 16,
    parameter int                TWOS_COMP  = 0,
    parameter logic [DATA_W-1:0] IDLE_CODE  = DATA_W'(IDLE_CODE_DEFAULT)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic [DIV_W-1:0]              rate_div,
    input  logic [DATA_W-1:0]             s_data,
    input  logic                          s_valid,
    output logic                          s_ready,
    output logic                          dac_clk,
    output logic [DATA_W-1:0]             dac_data,
    output logic                          dac_strobe,
    output logic                          underflow,
    output logic [15:0]                   underflow_cnt,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    function automatic logic [DATA_W-1:0] conv(input logic [DATA_W-1:0] x);
        return (TWOS_COMP != 0) ? x - DATA_W'(ADC_OFFSET) : x;
    endfunction

    state_t state, state_nx;
    logic [DIV_W-1:0] cnt, div_q;
    logic [DATA_W-1:0] head;
    logic full, empty, push, pop, flush, run, tick, enable_q;

    assign dac_clk = ~clk;
    assign run     = state == RUN && enable;
    assign tick    = run && cnt == div_q;

    dac_sample_tx_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk), .rst(rst), .push(push), .pop(pop), .flush(flush), .data(s_data),
        .head(head), .full(full), .empty(empty), .level(fifo_level)
    );

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // next state: IDLE -> PRIME -> RUN once half full; enable low always returns to IDLE
    always_comb begin
        state_nx = !enable ? IDLE
                 : state == RUN ? RUN
                 : (state == PRIME && fifo_level >= LW'(FIFO_DEPTH / 2)) ? RUN
                 : PRIME;
    end

    // FSM outputs: handshake, pop on tick, flush whenever stopped
    always_comb begin
        s_ready = state != IDLE && !full;
        push    = s_valid && s_ready;
        pop     = tick && !empty;
        flush   = !enable || state == IDLE;
    end

    // rate divider: free while running, reloads rate_div only at tick boundaries
    always_ff @(posedge clk) begin
        if (rst || !run) begin
            cnt   <= '0;
            div_q <= rate_div;
        end else if (tick) begin
            cnt   <= '0;
            div_q <= rate_div;
        end else begin
            cnt   <= cnt + 1'b1;
        end
    end

    // output register, strobes and saturating underflow counter
    always_ff @(posedge clk) begin
        if (rst) begin
            dac_data      <= conv(IDLE_CODE);
            dac_strobe    <= 1'b0;
            underflow     <= 1'b0;
            underflow_cnt <= '0;
            enable_q      <= 1'b0;
        end else begin
            enable_q      <= enable;
            dac_strobe    <= pop;
            underflow     <= tick && empty;
            dac_data      <= !enable ? conv(IDLE_CODE) : pop ? conv(head) : dac_data;
            underflow_cnt <= (enable && !enable_q) ? '0
                           : (tick && empty && underflow_cnt != 16'hFFFF) ? underflow_cnt + 1'b1
                           : underflow_cnt;
        end
    end
endmodule
